// File: rtl/lsu_mem_port_arbiter.sv
// LSU cache-port sequencer: picks a load or committed store, drives one
// outstanding request to the cache controller and returns load write-back.
module lsu_mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TAG_W        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              ld_vld_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [TAG_W-1:0]  ld_tag_i,
    output logic              ld_en_o,
    input  logic              st_vld_i,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [DATA_W-1:0] st_data_i,
    output logic              st_en_o,
    input  logic              sdq_full_i,
    output logic              cc_req_vld_o,
    output logic              cc_req_we_o,
    output logic [ADDR_W-1:0] cc_req_addr_o,
    output logic [DATA_W-1:0] cc_req_data_o,
    input  logic              cc_req_rdy_i,
    input  logic              cc_resp_vld_i,
    input  logic [DATA_W-1:0] cc_resp_data_i,
    output logic              ld_wb_vld_o,
    output logic [TAG_W-1:0]  ld_wb_tag_o,
    output logic [DATA_W-1:0] ld_wb_data_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic              kill;
    logic              lat_ld;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic [TAG_W-1:0]  lat_tag;
    logic              idle;
    logic              st_force;
    logic              ld_ok;
    logic              gnt_st;
    logic              gnt_ld;

    // Grant outputs are combinational, so hold them off while reset is low.
    always_comb begin
        idle     = rst_i && (state == S_IDLE);
        st_force = st_vld_i && (sdq_full_i || (cnt == LIMIT));
        ld_ok    = ld_vld_i && !flush_i;
        gnt_st   = idle && st_vld_i && (st_force || !ld_ok);
        gnt_ld   = idle && ld_ok && !st_force;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (gnt_st || gnt_ld) state_nxt = S_REQ;
            S_REQ: begin
                if (flush_i && lat_ld)  state_nxt = S_IDLE;
                else if (cc_req_rdy_i)  state_nxt = S_WAIT;
            end
            S_WAIT: if (cc_resp_vld_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= S_IDLE;
            cnt      <= '0;
            kill     <= 1'b0;
            lat_ld   <= 1'b0;
            lat_we   <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_tag  <= '0;
        end else begin
            state <= state_nxt;
            if (gnt_st || gnt_ld) begin
                lat_ld   <= gnt_ld;
                lat_we   <= gnt_st;
                lat_addr <= gnt_st ? st_addr_i : ld_addr_i;
                lat_data <= gnt_st ? st_data_i : '0;
                lat_tag  <= ld_tag_i;
            end
            if (state_nxt == S_IDLE)
                kill <= 1'b0;
            else if (state == S_WAIT && flush_i && lat_ld)
                kill <= 1'b1;
            if (gnt_st)
                cnt <= '0;
            else if (gnt_ld && st_vld_i && cnt != LIMIT)
                cnt <= cnt + 4'd1;
            else if (state == S_IDLE && !st_vld_i)
                cnt <= '0;
        end
    end

    // A flush in the response cycle itself also discards the load.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ld_wb_vld_o  <= 1'b0;
            ld_wb_tag_o  <= '0;
            ld_wb_data_o <= '0;
        end else begin
            ld_wb_vld_o <= 1'b0;
            if (state == S_WAIT && cc_resp_vld_i && lat_ld && !kill && !flush_i) begin
                ld_wb_vld_o  <= 1'b1;
                ld_wb_tag_o  <= lat_tag;
                ld_wb_data_o <= cc_resp_data_i;
            end
        end
    end

    assign ld_en_o       = gnt_ld;
    assign st_en_o       = gnt_st;
    assign cc_req_vld_o  = (state == S_REQ);
    assign cc_req_we_o   = lat_we;
    assign cc_req_addr_o = lat_addr;
    assign cc_req_data_o = lat_data;
    assign busy_o        = (state != S_IDLE);

endmodule
